bpred_bht: RTL
==============

# bpred_bht

Dynamic branch predictor for the fetch stage. Looks up the fetch PC each cycle and predicts conditional-branch direction and target from a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating counters (PHT). When the EX-stage branch comparator resolves a conditional branch, the block receives the actual outcome and flags any misprediction. It also supplies the redirect PC and trains its tables.

## Interface
- `XLEN`, 32: address/data width.
- `IDX_W`, 6: index bits; BTB and PHT each hold 2^IDX_W entries.
- `TAG_W`, 8: BTB tag bits.
- `GHR_W`, 6: global history width (used only with the configuration macro; must be ≤ IDX_W).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_pc` in XLEN: fetch PC.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `pred_ghr` out GHR_W: history snapshot at prediction; the pipeline carries it to EX. Driven 0 without the macro.
- `ex_valid` in 1: a conditional branch resolves this cycle.
- `ex_pc` in XLEN: PC of the resolving branch.
- `ex_taken` in 1: actual outcome from the branch comparator.
- `ex_target` in XLEN: computed taken target.
- `ex_pred_taken` in 1: prediction carried from fetch.
- `ex_pred_target` in XLEN: predicted next PC carried from fetch.
- `ex_ghr` in GHR_W: `pred_ghr` carried from fetch. Ignored without the macro.
- `mispredict` out 1: the resolving branch was mispredicted.
- `redirect_pc` out XLEN: correct next PC.

## Operation
- Index `idx = pc[IDX_W+1:2]`. Tag `tag = pc[IDX_W+TAG_W+1:IDX_W+2]`.
- BTB entry fields: `valid`, `tag`, `target`. PHT entry: 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup: `hit = valid[idx] && tag matches`.
  - `pred_taken = hit && pht[pidx][1]`, where `pidx = idx` (or the hashed index under the macro).
  - `pred_target` = BTB target when `pred_taken`, else `if_pc + 4` (mod 2^XLEN).
- Resolve, combinational, qualified by `ex_valid`:
  - `mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target))`.
  - `redirect_pc = ex_taken ? ex_target : ex_pc + 4`.
  - When `ex_valid = 0`: `mispredict = 0` and `redirect_pc` is don't-care.
- Training on `ex_valid`:
  - **BTB hit:** the PHT counter saturating-increments on taken and decrements on not-taken (11 stays 11, 00 stays 00). If taken, the target is rewritten.
  - **BTB miss and taken:** allocate the entry (valid, tag, target) and set the counter to 10.
  - **BTB miss and not taken:** no change.
- Aliasing between PCs with equal index and different tag: the new entry replaces the old one.

## Timing
- Prediction is combinational from `if_pc` (zero latency). `mispredict` and `redirect_pc` are combinational from the `ex_*` inputs.
- Table and history writes occur at `posedge clk`.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. The update is visible to a lookup on the next cycle.
- Reset (async, any time, including mid-update):
  - All `valid` bits cleared, all counters set to 01, GHR cleared.
  - Outputs immediately: `pred_taken = 0`, `pred_target = if_pc + 4`, `pred_ghr = 0`.
  - Any update in flight is discarded.

## Configuration
- `BPRED_GSHARE_EN` defined:
  - `pidx = idx ^ {0, ghr}` at lookup.
  - Training uses `ex_pc` index XOR `ex_ghr`.
  - On `ex_valid`, `ghr <= {ghr[GHR_W-2:0], ex_taken}` (non-speculative).
  - `pred_ghr = ghr`.
- Undefined: `pidx = idx`, no GHR register, `pred_ghr = 0`, `ex_ghr` ignored.
- The BTB is always PC-indexed.

## Structure
- Package `bpred_pkg` holds:
  - Counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - Reset counter value `CTR_RST = CTR_WNT` and allocation value `CTR_ALLOC = CTR_WT`.
  - BTB entry typedef.
- Sub-module `bpred_sat_ctr2`: pure 2-bit saturating-update function block, instanced on the training path.

## Test plan
- **Cold lookup:** reset, `if_pc = 0x104` -> `pred_taken = 0`, `pred_target = 0x108`.
- **Allocate:** `ex_valid`, `ex_pc = 0x104`, taken, target `0x200`, `ex_pred_taken = 0` -> `mispredict = 1`, `redirect_pc = 0x200`. Next cycle `if_pc = 0x104` -> taken, `0x200`.
- **Saturation:** three not-taken resolves of `0x104` -> counter 10→01→00→00, prediction 0 after the first. One taken resolve -> 01, still predicts not-taken.
- **Same-cycle conflict and alias:**
  - Update and lookup of `0x104` in the same cycle -> old prediction returned.
  - After allocation, `if_pc = 0x204` (same idx, tag 0x02) -> `pred_taken = 0`, target `0x208`.
- **Async reset mid-operation:** trained entry, drop `rst_n` between clock edges -> `pred_taken` falls to 0 without a clock. Lookup of `0x104` after release misses.
- **`BPRED_GSHARE_EN`:**
  - Resolve taken, taken -> `pred_ghr = 0b000011`.
  - `ex_ghr` mismatch with the live GHR -> the PHT entry trained is the one at `ex_ghr`.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types and constants for the bpred_bht branch predictor.
//   ctr_e        - 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   CTR_RST      - counter value after reset (weakly not-taken)
//   CTR_ALLOC    - counter value written when a BTB entry is allocated
//   btb_entry_t  - one BTB line: valid, tag, target
// The BTB entry shape is fixed by BTB_TAG_W/BTB_XLEN; instantiate bpred_bht
// with matching TAG_W/XLEN.
package bpred_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST   = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

  localparam int unsigned BTB_TAG_W = 8;
  localparam int unsigned BTB_XLEN  = 32;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_XLEN-1:0]  target;
  } btb_entry_t;

endpackage

// File: rtl/bpred_sat_ctr2.sv
// bpred_sat_ctr2: combinational 2-bit saturating counter update.
//   ctr      in  - current counter value
//   up       in  - 1: increment (taken), 0: decrement (not taken)
//   ctr_next out - updated value, clamped at CTR_SNT / CTR_ST
module bpred_sat_ctr2
  import bpred_pkg::*;
(
  input  ctr_e ctr,
  input  logic up,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      CTR_SNT: ctr_next = up ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_next = up ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_next = up ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_next = up ? CTR_ST  : CTR_WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/bpred_bht.sv
// bpred_bht: fetch-stage branch predictor (direct-mapped BTB + 2-bit PHT).
//   clk, rst_n        - clock, asynchronous active-low reset
//   if_pc             - fetch PC; pred_taken/pred_target/pred_ghr are
//                       combinational from it
//   ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
//   ex_ghr            - resolving conditional branch from EX
//   mispredict, redirect_pc - combinational resolve outputs
// Optional feature: define BPRED_GSHARE_EN to index the PHT with
// PC index XOR global history (non-speculative GHR updated at resolve).
module bpred_bht
  import bpred_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [GHR_W-1:0] ex_ghr,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  btb_entry_t btb_q [DEPTH];
  ctr_e       pht_q [DEPTH];

  logic [IDX_W-1:0] idx, pidx, e_idx, e_pidx;
  logic [TAG_W-1:0] tag, e_tag;
  logic             hit, e_hit;
  ctr_e             ctr_rd, e_ctr, e_ctr_next;

  assign idx   = if_pc[IDX_W+1:2];
  assign tag   = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  // History is shifted only at resolve, so it is non-speculative; training
  // uses the snapshot carried with the branch, not the live register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (ex_valid) begin
      ghr_q <= {ghr_q[GHR_W-2:0], ex_taken};
    end
  end

  assign pidx     = idx ^ IDX_W'(ghr_q);
  assign e_pidx   = e_idx ^ IDX_W'(ex_ghr);
  assign pred_ghr = ghr_q;
`else
  logic unused_ex_ghr;

  assign unused_ex_ghr = ^ex_ghr;
  assign pidx          = idx;
  assign e_pidx        = e_idx;
  assign pred_ghr      = '0;
`endif

  // Lookup
  assign hit         = btb_q[idx].valid && (btb_q[idx].tag == tag);
  assign ctr_rd      = pht_q[pidx];
  assign pred_taken  = hit && ctr_rd[1];
  assign pred_target = pred_taken ? btb_q[idx].target : if_pc + XLEN'(4);

  // Resolve
  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  // Training
  assign e_hit = btb_q[e_idx].valid && (btb_q[e_idx].tag == e_tag);
  assign e_ctr = pht_q[e_pidx];

  bpred_sat_ctr2 u_sat_ctr (
    .ctr      (e_ctr),
    .up       (ex_taken),
    .ctr_next (e_ctr_next)
  );

  // Only valid bits need clearing; tag/target are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        btb_q[i].valid <= 1'b0;
        pht_q[i]       <= CTR_RST;
      end
    end else if (ex_valid) begin
      if (e_hit) begin
        pht_q[e_pidx] <= e_ctr_next;
        if (ex_taken) begin
          btb_q[e_idx].target <= ex_target;
        end
      end else if (ex_taken) begin
        // Allocation overwrites any aliasing entry at this index.
        btb_q[e_idx].valid  <= 1'b1;
        btb_q[e_idx].tag    <= e_tag;
        btb_q[e_idx].target <= ex_target;
        pht_q[e_pidx]       <= CTR_ALLOC;
      end
    end
  end

endmodule
